// File: rtl/score_keeper.sv
// Per-player point counter with rising-edge detection and match-winner detection.
// Drives the restart/winner feedback into control_game and two active-low 7-segment displays.
module score_keeper #(
   parameter int WIN_SCORE = 7,
   parameter int SCORE_W   = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               clear,
   input  logic               p0_point,
   input  logic               p1_point,
   output logic [SCORE_W-1:0] p0_score,
   output logic [SCORE_W-1:0] p1_score,
   output logic               match_over,
   output logic               winner,
   output logic               win_pulse,
   output logic [6:0]         hex0,
   output logic [6:0]         hex2
);

   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

   localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] p0_score_q, p0_score_d;
   logic [SCORE_W-1:0] p1_score_q, p1_score_d;
   logic               p0_prev_q, p0_prev_d;
   logic               p1_prev_q, p1_prev_d;
   logic               winner_q, winner_d;
   logic               win_pulse_q, win_pulse_d;

   logic               rise0, rise1;
   logic [SCORE_W-1:0] next_p0, next_p1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= PLAY;
         p0_score_q  <= '0;
         p1_score_q  <= '0;
         p0_prev_q   <= 1'b0;
         p1_prev_q   <= 1'b0;
         winner_q    <= 1'b0;
         win_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         p0_score_q  <= p0_score_d;
         p1_score_q  <= p1_score_d;
         p0_prev_q   <= p0_prev_d;
         p1_prev_q   <= p1_prev_d;
         winner_q    <= winner_d;
         win_pulse_q <= win_pulse_d;
      end
   end

   always_comb begin
      rise0       = p0_point & ~p0_prev_q;
      rise1       = p1_point & ~p1_prev_q;
      next_p0     = p0_score_q + SCORE_W'(rise0);
      next_p1     = p1_score_q + SCORE_W'(rise1);

      state_d     = state_q;
      p0_score_d  = p0_score_q;
      p1_score_d  = p1_score_q;
      p0_prev_d   = p0_point;
      p1_prev_d   = p1_point;
      winner_d    = winner_q;
      win_pulse_d = 1'b0;

      // Edge history keeps sampling through clear, so a held input is not recounted.
      if (clear) begin
         state_d    = PLAY;
         p0_score_d = '0;
         p1_score_d = '0;
         winner_d   = 1'b0;
      end else begin
         case (state_q)
            PLAY: begin
               p0_score_d = next_p0;
               p1_score_d = next_p1;
               if ((next_p0 == WIN_VAL) || (next_p1 == WIN_VAL)) begin
                  state_d     = OVER;
                  win_pulse_d = 1'b1;
                  winner_d    = (next_p0 == WIN_VAL);
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign p0_score   = p0_score_q;
   assign p1_score   = p1_score_q;
   assign match_over = (state_q == OVER);
   assign winner     = winner_q;
   assign win_pulse  = win_pulse_q;
   assign hex0       = seg7(4'(p0_score_q));
   assign hex2       = seg7(4'(p1_score_q));

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed stimulus for score_keeper, checked against a point-counting reference model.
module tb_score_keeper;

   localparam int WIN = 7;
   localparam int SW  = 4;

   logic          clk;
   logic          resetn;
   logic          clear;
   logic          p0_point;
   logic          p1_point;
   logic [SW-1:0] p0_score;
   logic [SW-1:0] p1_score;
   logic          match_over;
   logic          winner;
   logic          win_pulse;
   logic [6:0]    hex0;
   logic [6:0]    hex2;

   int checks   = 0;
   int failures = 0;

   // Reference model state: plain integer scores plus the last sampled input levels.
   int   m_p0, m_p1;
   bit   m_last0, m_last1;
   bit   m_over, m_win, m_pulse;
   int   pulse_count;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   score_keeper #(.WIN_SCORE(WIN), .SCORE_W(SW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (clear),
      .p0_point   (p0_point),
      .p1_point   (p1_point),
      .p0_score   (p0_score),
      .p1_score   (p1_score),
      .match_over (match_over),
      .winner     (winner),
      .win_pulse  (win_pulse),
      .hex0       (hex0),
      .hex2       (hex2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p0 = 0; m_p1 = 0;
      m_last0 = 0; m_last1 = 0;
      m_over = 0; m_win = 0; m_pulse = 0;
   endtask

   // One clock edge of the game rules: a point counts when its input is high now but was low last edge.
   task automatic model_edge(input bit a, input bit b, input bit c);
      bit new0, new1;
      new0 = a && !m_last0;
      new1 = b && !m_last1;
      m_last0 = a;
      m_last1 = b;
      m_pulse = 0;
      if (c) begin
         m_p0 = 0; m_p1 = 0; m_over = 0; m_win = 0;
      end else if (!m_over) begin
         if (new0) m_p0 = m_p0 + 1;
         if (new1) m_p1 = m_p1 + 1;
         if (m_p0 == WIN || m_p1 == WIN) begin
            m_over  = 1;
            m_pulse = 1;
            m_win   = (m_p0 == WIN);
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".p0"},   32'(p0_score),   32'(m_p0));
      check({tag, ".p1"},   32'(p1_score),   32'(m_p1));
      check({tag, ".over"}, 32'(match_over), 32'(m_over));
      check({tag, ".win"},  32'(winner),     32'(m_win));
      check({tag, ".pls"},  32'(win_pulse),  32'(m_pulse));
      check({tag, ".hex0"}, 32'(hex0),       32'(hex_tab[m_p0 % 16]));
      check({tag, ".hex2"}, 32'(hex2),       32'(hex_tab[m_p1 % 16]));
   endtask

   // driver: set inputs away from the edge, advance one edge, then compare
   task automatic step(input string tag, input logic a, input logic b, input logic c);
      @(negedge clk);
      p0_point = a; p1_point = b; clear = c;
      @(posedge clk);
      model_edge(a, b, c);
      if (m_pulse) pulse_count++;
      #1 check_all(tag);
   endtask

   initial begin
      resetn = 1'b0; clear = 1'b0; p0_point = 1'b0; p1_point = 1'b0;
      model_reset();
      pulse_count = 0;
      repeat (3) @(posedge clk);
      #1 check_all("reset");
      check("reset.hex0_lit", 32'(hex0), 32'h40);
      @(negedge clk) resetn = 1'b1;

      // three single-cycle pulses, four cycles apart
      for (int i = 0; i < 3; i++) begin
         step("pulse", 1, 0, 0);
         repeat (3) step("pulse_gap", 0, 0, 0);
      end
      check("three.p0", 32'(p0_score), 32'd3);
      check("three.hex0", 32'(hex0), 32'b0110000);
      check("three.over", 32'(match_over), 32'd0);

      // long hold counts once
      repeat (50) step("hold1", 0, 1, 0);
      step("hold1_rel", 0, 0, 0);
      check("hold.p1", 32'(p1_score), 32'd1);

      // player 0 wins with seven rises, then later rises are ignored
      step("clr", 0, 0, 1);
      pulse_count = 0;
      for (int i = 0; i < WIN; i++) begin
         step("win0_hi", 1, 0, 0);
         step("win0_lo", 0, 0, 0);
      end
      check("win0.p0", 32'(p0_score), 32'(WIN));
      check("win0.winner", 32'(winner), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step("frozen_hi", 1, 1, 0);
         step("frozen_lo", 0, 0, 0);
      end
      check("win0.pulses", 32'(pulse_count), 32'd1);
      check("frozen.p1", 32'(p1_score), 32'd0);

      // simultaneous win from 6/6
      step("clr", 0, 0, 1);
      for (int i = 0; i < WIN - 1; i++) begin
         step("tie_hi", 1, 1, 0);
         step("tie_lo", 0, 0, 0);
      end
      step("tie_win", 1, 1, 0);
      check("tie.p0", 32'(p0_score), 32'(WIN));
      check("tie.p1", 32'(p1_score), 32'(WIN));
      check("tie.winner", 32'(winner), 32'd1);

      // clear held three cycles while p1 stays high: no count until a fresh rise
      repeat (3) step("clr_hold", 0, 1, 1);
      repeat (4) step("post_clr_held", 0, 1, 0);
      check("post_clr.p1", 32'(p1_score), 32'd0);
      check("post_clr.over", 32'(match_over), 32'd0);
      step("p1_fall", 0, 0, 0);
      step("p1_rise", 0, 1, 0);
      check("fresh.p1", 32'(p1_score), 32'd1);

      // randomized play with occasional clears
      step("clr", 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 59) == 0));
      end

      // asynchronous reset mid-cycle at 4/2
      step("clr", 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step("pre_rst_hi", 1, (i < 2), 0);
         step("pre_rst_lo", 0, 0, 0);
      end
      check("pre_rst.p0", 32'(p0_score), 32'd4);
      check("pre_rst.p1", 32'(p1_score), 32'd2);
      @(negedge clk);
      #2 resetn = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      check("async_rst.hex2_lit", 32'(hex2), 32'h40);
      @(negedge clk) resetn = 1'b1;
      step("after_rst", 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Synchronous scoring stage that sits directly downstream of `control_game`. It consumes the ball datapaths' `player_0_scores` / `player_1_scores` level signals, counts each rising edge exactly once into per-player scores, and detects the match winner. It drives the `restart` and `winner` inputs back into `control_game` and the HEX0/HEX2 displays. All state is clocked by the single system clock.

## Interface
- `WIN_SCORE`, default 7: score value that ends the match; legal range 1..15.
- `SCORE_W`, default 4: score register width; must satisfy `2**SCORE_W > WIN_SCORE`.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous match clear, driven by `erase_all`.
- `p0_point` in 1: player 0 scored; a level that may stay high for many cycles.
- `p1_point` in 1: player 1 scored; a level that may stay high for many cycles.
- `p0_score` out SCORE_W: registered player 0 score.
- `p1_score` out SCORE_W: registered player 1 score.
- `match_over` out 1: registered, sticky; drives `restart`.
- `winner` out 1: registered; 1 = player 0 won, 0 = player 1 won. Valid only while `match_over` is 1.
- `win_pulse` out 1: registered, one-cycle strobe on the cycle `match_over` rises.
- `hex0` out 7: active-low 7-segment encoding of `p0_score`.
- `hex2` out 7: active-low 7-segment encoding of `p1_score`.

## Operation
- Edge detection: registers `p0_prev` / `p1_prev` capture their inputs every cycle.
  - `rise0 = p0_point & ~p0_prev`; `rise1` is formed the same way.
  - A held-high input counts exactly once.
- State machine, two states:
  - PLAY: scoring enabled.
  - OVER: scores frozen; all rises are ignored; `match_over` is 1.
- PLAY behaviour:
  - `rise0` increments `p0_score`; `rise1` increments `p1_score`. Both increment if both rise in the same cycle.
  - Win check uses the next-score values: if `next_p0 == WIN_SCORE` or `next_p1 == WIN_SCORE`, go to OVER on that same edge.
  - On entering OVER: `match_over` is set to 1 and `win_pulse` is 1 for exactly one cycle.
  - `winner` is 1 if `next_p0 == WIN_SCORE`, else 0.
  - Simultaneous win (both reach WIN_SCORE on the same edge): player 0 wins, `winner` = 1.
- OVER → PLAY only via `clear` or reset.
- `clear` (synchronous, highest priority after reset), in either state:
  - Scores go to 0, `match_over` to 0, `winner` to 0, `win_pulse` to 0; state goes to PLAY.
  - Any rise in the `clear` cycle is discarded.
  - `p*_prev` registers still sample normally, so an input held high across `clear` is not counted afterwards.
- Scores never exceed WIN_SCORE; no wrap-around is possible because scoring stops in OVER.
- Hex encoding:
  - Combinational from the registered scores; standard DE1 active-low encoding, bit 6 = segment g.
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
  - A–F use the standard hex glyphs.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Scores 0, `p*_prev` 0, `match_over` 0, `winner` 0, `win_pulse` 0, state PLAY.
  - `hex0` = `hex2` = 1000000.
- Latency: an input that goes high before edge k is reflected in `p*_score` after edge k, i.e. 1 cycle.
  - `match_over`, `winner` and `win_pulse` update on that same edge k.
- Minimum input spacing for two counted points: one low sample between highs (high, low, high counts 2).
- Reset asserted mid-match: all state clears immediately, independent of `clk`.
- `clear` held for N cycles: outputs stay at their cleared values; scoring resumes on the first cycle `clear` is low, counting only new rises.

## Test plan
- Reset, then pulse `p0_point` high for 1 cycle three times, 4 cycles apart → `p0_score`=3, `p1_score`=0, `hex0`=0110000, `match_over`=0.
- Hold `p1_point` high for 50 cycles → `p1_score` increments once, to 1.
- Give player 0 seven rises with WIN_SCORE=7 → after the 7th edge: `p0_score`=7, `match_over`=1, `winner`=1, `win_pulse` high exactly 1 cycle. Further rises on either input leave the scores at 7/0.
- Set scores to 6/6, then raise both inputs in the same cycle → 7/7, `match_over`=1, `winner`=1.
- In OVER, assert `clear` for 3 cycles while `p1_point` is held high; release `clear` → scores 0/0, `match_over`=0, `winner`=0, and no increment until `p1_point` falls and rises again.
- Drop `resetn` asynchronously mid-clock with scores at 4/2 → outputs go to 0/0 and `hex` = 1000000 before the next `clk` edge.
